// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Issue stage in front of a combinational 8-bit ALU. Commands are
//             queued in a small FIFO and driven one at a time onto registered
//             ALU inputs. The ALU result and flags are captured into a result
//             register, which is offered downstream through valid/ready. An
//             accumulator (last captured result) can replace operand a.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             cmd_valid/cmd_ready        - command handshake (ready = !full)
//             cmd_a/cmd_b/cmd_op/cmd_use_acc - command payload
//             alu_a/alu_b/alu_opcode     - registered drive to the ALU
//             alu_out/alu_carry/alu_borrow/alu_overflow/alu_zero - ALU result
//             res_valid/res_ready        - result handshake
//             res_out/res_carry/res_borrow/res_overflow/res_zero - result
//             acc                        - accumulator
//             op_count                   - results consumed (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_borrow,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_carry,
    output logic             res_borrow,
    output logic             res_overflow,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic [15:0]      op_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_EW = 2 * WIDTH + 4;   // {a, b, op[2:0], use_acc}

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    localparam logic [c_AW:0] c_PTR_ONE = 1;
    localparam logic [15:0]   c_CNT_ONE = 16'd1;

    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_out;
    logic             r_res_carry;
    logic             r_res_borrow;
    logic             r_res_overflow;
    logic             r_res_zero;
    logic [WIDTH-1:0] r_acc;
    logic [15:0]      r_op_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_consume;
    logic [c_EW-1:0]  w_head;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic [2:0]       w_head_op;
    logic             w_head_use_acc;

    // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // A full FIFO never accepts, even if the head is popped on the same edge.
    assign w_push    = cmd_valid && !w_full;
    assign w_consume = (r_state == c_HOLD) && r_res_valid && res_ready;
    // Pop from IDLE, or back-to-back from HOLD on the edge the result leaves.
    assign w_pop     = !w_empty && ((r_state == c_IDLE) || w_consume);

    assign w_head         = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_head_a       = w_head[c_EW-1 -: WIDTH];
    assign w_head_b       = w_head[WIDTH+3 -: WIDTH];
    assign w_head_op      = w_head[3:1];
    assign w_head_use_acc = w_head[0];

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {cmd_a, cmd_b, cmd_op, cmd_use_acc};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_state        <= c_IDLE;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_res_valid    <= 1'b0;
            r_res_out      <= '0;
            r_res_carry    <= 1'b0;
            r_res_borrow   <= 1'b0;
            r_res_overflow <= 1'b0;
            r_res_zero     <= 1'b0;
            r_acc          <= '0;
            r_op_count     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end

            // Accumulator selection happens here, at pop time, so it sees the
            // result captured for the immediately preceding command.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_alu_a  <= w_head_use_acc ? r_acc : w_head_a;
                r_alu_b  <= w_head_b;
                r_alu_op <= w_head_op;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_res_out      <= alu_out;
                    r_res_carry    <= alu_carry;
                    r_res_borrow   <= alu_borrow;
                    r_res_overflow <= alu_overflow;
                    r_res_zero     <= alu_zero;
                    r_acc          <= alu_out;
                    r_res_valid    <= 1'b1;
                    r_state        <= c_HOLD;
                end
                c_HOLD: begin
                    if (w_consume) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + c_CNT_ONE;
                        r_state     <= w_pop ? c_EXEC : c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = !w_full;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_op;
    assign res_valid    = r_res_valid;
    assign res_out      = r_res_out;
    assign res_carry    = r_res_carry;
    assign res_borrow   = r_res_borrow;
    assign res_overflow = r_res_overflow;
    assign res_zero     = r_res_zero;
    assign acc          = r_acc;
    assign op_count     = r_op_count;

endmodule
`default_nettype wire
